// File: rtl/riscv_pkg.sv
// Shared package: arbitration mode enum and a wrap-around increment helper.
package riscv_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Returns (idx + 1) mod n for small non-negative indices.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant generator: fixed-priority or round-robin
// starting at ptr, wrapping from N_IN-1 back to 0.
module rr_arbiter import riscv_pkg::*; #(
  parameter int        N_IN  = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  int base;
  logic found;

  // Scan requests from the search base and grant the first one found.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    base      = (MODE == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N_IN; k++) begin
      int idx;
      idx = (base + k) % N_IN;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-input arbitrated mux with a single registered output stage and
// valid/ready handshaking on both sides.
module arb_mux import riscv_pkg::*; #(
  parameter int        WIDTH = 32,
  parameter int        N_IN  = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_IN-1:0][WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]            in_valid,
  output logic [N_IN-1:0]            in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_W-1:0]           out_sel
);

  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] ptr;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             in_xfer;

  rr_arbiter #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Output register is free when empty or being drained this cycle;
  // reset_n gating keeps every ready low while reset is held.
  always_comb begin
    can_load = ~out_valid | out_ready;
    in_ready = grant & {N_IN{can_load & reset_n}};
    in_xfer  = |(in_valid & in_ready);
  end

  // One-hot AND-OR payload select: no priority chain on the data path.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      sel_data = sel_data | (in_data[i] & {WIDTH{grant[i]}});
    end
  end

  // ---- stage boundary: output register ----
  // Capture on input transfer, drop valid once drained with nothing new.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner only when a beat is taken,
  // so a stalled grant stays put under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (MODE == ARB_RR && in_xfer) begin
      ptr <= SEL_W'(wrap_inc(int'(grant_idx), N_IN));
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed and randomized checks for arb_mux in round-robin and fixed modes.
module tb_arb_mux;
  import riscv_pkg::*;

  logic             clk;
  logic             reset_n;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_valid;
  logic             out_ready;

  logic [3:0]  rr_in_ready, fx_in_ready;
  logic [31:0] rr_out_data, fx_out_data;
  logic        rr_out_valid, fx_out_valid;
  logic [1:0]  rr_out_sel, fx_out_sel;

  int errors = 0;
  int checks = 0;

  arb_mux #(.WIDTH(32), .N_IN(4), .MODE(ARB_RR)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_valid(rr_out_valid),
    .out_ready(out_ready), .out_sel(rr_out_sel)
  );

  arb_mux #(.WIDTH(32), .N_IN(4), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fx_in_ready), .out_data(fx_out_data), .out_valid(fx_out_valid),
    .out_ready(out_ready), .out_sel(fx_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) in_data[i] = 32'hA000_0000 + i;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; set_data();
    #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", rr_out_valid); end
    checks++; if (rr_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", rr_out_data); end
    checks++; if (rr_out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", rr_out_sel); end
    checks++; if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", rr_in_ready); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (rr_out_valid !== 1'b0 || dut.ptr !== 2'd0) begin errors++; $display("FAIL reset_held got valid=%b ptr=%0d want 0/0", rr_out_valid, dut.ptr); end
    reset_n = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL first_ready got %b want 0001", rr_in_ready); end
    @(posedge clk); #1;
    checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 || rr_out_data !== 32'hA000_0000) begin
      errors++; $display("FAIL first_beat got v=%b sel=%0d data=%h want 1/0/a0000000", rr_out_valid, rr_out_sel, rr_out_data); end
  endtask

  task automatic test_rr_sequence();
    logic [1:0] exp_sel;
    do_reset();
    set_data(); in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      exp_sel = 2'(k % 4);
      checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== exp_sel || rr_out_data !== (32'hA000_0000 + 32'(k % 4))) begin
        errors++; $display("FAIL rr_seq[%0d] got v=%b sel=%0d data=%h want 1/%0d", k, rr_out_valid, rr_out_sel, rr_out_data, exp_sel); end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    set_data(); in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    checks++; if (fx_in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_ready0 got %b want 0010", fx_in_ready); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++; if (fx_out_valid !== 1'b1 || fx_out_sel !== 2'd1 || fx_in_ready !== 4'b0010) begin
        errors++; $display("FAIL fixed[%0d] got v=%b sel=%0d rdy=%b want 1/1/0010", k, fx_out_valid, fx_out_sel, fx_in_ready); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(); in_data[2] = 32'hDEAD_BEEF; in_valid = 4'b0100; out_ready = 1'b0;
    #1;
    checks++; if (rr_in_ready !== 4'b0100) begin errors++; $display("FAIL bp_ready0 got %b want 0100", rr_in_ready); end
    @(posedge clk); #1;
    // Other channels now request with new data; the held beat must not change.
    in_valid = 4'hF; in_data[2] = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hDEAD_BEEF || rr_out_sel !== 2'd2 || rr_in_ready !== 4'b0000 || dut.ptr !== 2'd3) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b data=%h sel=%0d rdy=%b ptr=%0d want 1/deadbeef/2/0000/3",
                           k, rr_out_valid, rr_out_data, rr_out_sel, rr_in_ready, dut.ptr); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b want 1000", rr_in_ready); end
    @(posedge clk); #1;
    checks++; if (rr_out_sel !== 2'd3 || rr_out_data !== 32'hA000_0003) begin
      errors++; $display("FAIL bp_release_beat got sel=%0d data=%h want 3/a0000003", rr_out_sel, rr_out_data); end
  endtask

  task automatic test_drop_valid();
    do_reset();
    set_data(); in_valid = 4'b0001; out_ready = 1'b0;
    @(posedge clk); #1;
    // Channel 1 waits behind the stalled output, then withdraws; channel 3 takes over.
    in_valid = 4'b0010;
    @(posedge clk); #1;
    in_valid = 4'b1000; out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b1000) begin errors++; $display("FAIL drop_ready got %b want 1000", rr_in_ready); end
    @(posedge clk); #1;
    in_valid = 4'b0000;
    checks++; if (rr_out_sel !== 2'd3 || rr_out_data !== 32'hA000_0003) begin
      errors++; $display("FAIL drop_beat got sel=%0d data=%h want 3/a0000003", rr_out_sel, rr_out_data); end
    @(posedge clk); #1;
    checks++; if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL drop_drain got v=%b want 0", rr_out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_data(); in_valid = 4'b0100; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (dut.ptr !== 2'd3) begin errors++; $display("FAIL wrap_ptr3 got %0d want 3", dut.ptr); end
    in_valid = 4'b0010;
    #1;
    checks++; if (rr_in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready got %b want 0010", rr_in_ready); end
    @(posedge clk); #1;
    checks++; if (rr_out_sel !== 2'd1 || dut.ptr !== 2'd2) begin
      errors++; $display("FAIL wrap_grant got sel=%0d ptr=%0d want 1/2", rr_out_sel, dut.ptr); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_data(); in_valid = 4'hF; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (rr_out_valid !== 1'b1 || dut.ptr !== 2'd1) begin
      errors++; $display("FAIL mid_setup got v=%b ptr=%0d want 1/1", rr_out_valid, dut.ptr); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (rr_out_valid !== 1'b0 || rr_out_data !== 32'h0 || rr_in_ready !== 4'b0000 || dut.ptr !== 2'd0) begin
      errors++; $display("FAIL mid_async got v=%b data=%h rdy=%b ptr=%0d want 0/0/0000/0", rr_out_valid, rr_out_data, rr_in_ready, dut.ptr); end
    #1;
    reset_n = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL mid_release_ready got %b want 0001", rr_in_ready); end
    @(posedge clk); #1;
    checks++; if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0) begin
      errors++; $display("FAIL mid_first_grant got v=%b sel=%0d want 1/0", rr_out_valid, rr_out_sel); end
  endtask

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (g == 4'b0000 && v[(p + k) % 4]) g[(p + k) % 4] = 1'b1;
    end
    return g;
  endfunction

  task automatic test_random();
    logic [33:0] q[$];
    logic [33:0] head;
    logic [3:0]  exp_grant, exp_ready;
    int          m_ptr;
    logic        m_ov;
    int          idx;
    do_reset();
    m_ptr = 0; m_ov = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) in_data[i] = $urandom();
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_grant = model_grant(in_valid, m_ptr);
      exp_ready = (!m_ov || out_ready) ? exp_grant : 4'b0000;
      checks++; if (rr_in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, rr_in_ready, exp_ready); end
      if (m_ov && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_underflow[%0d] got output beat want none", c);
        end else begin
          head = q.pop_front();
          checks++; if ({rr_out_sel, rr_out_data} !== head) begin
            errors++; $display("FAIL rand_beat[%0d] got sel=%0d data=%h want sel=%0d data=%h",
                               c, rr_out_sel, rr_out_data, head[33:32], head[31:0]); end
        end
      end
      if (exp_ready != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (exp_ready[i]) idx = i;
        q.push_back({2'(idx), in_data[idx]});
        m_ptr = (idx + 1) % 4;
        m_ov  = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
      checks++; if (rr_out_valid !== m_ov) begin
        errors++; $display("FAIL rand_valid[%0d] got %b want %b", c, rr_out_valid, m_ov); end
    end
    checks++; if (q.size() != (m_ov ? 1 : 0)) begin
      errors++; $display("FAIL rand_leftover got %0d want %0d", q.size(), m_ov ? 1 : 0); end
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_fixed();
    test_backpressure();
    test_drop_valid();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
